// File: rtl/cpu_pkg.sv
// Shared CPU definitions: microword bit positions, control-store sizing and the
// control-store sequencing state encoding.
package cpu_pkg;
  localparam int CS_AW = 8;
  localparam int CS_DW = 32;

  localparam int MW_INC      = 0;
  localparam int MW_DISPATCH = 1;
  localparam int MW_ZERO     = 2;
  localparam int MW_HALT     = 31;

  typedef enum logic [1:0] {LOAD, FETCH, EXEC, HALT} cs_state_t;
endpackage

// File: rtl/cs_ram.sv
// Control-store array: synchronous write port, asynchronous read port.
module cs_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/control_store.sv
// Writable microprogram store with registered microword output and a
// LOAD/FETCH/EXEC/HALT sequencer. Optional CONTROL_STORE_UCOUNT_EN adds ucount.
module control_store
  import cpu_pkg::*;
#(
  parameter int AW       = CS_AW,
  parameter int DW       = CS_DW,
  parameter int HALT_BIT = MW_HALT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] micro_addr,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  input  logic          restart,
  output logic [DW-1:0] control_signal,
`ifdef CONTROL_STORE_UCOUNT_EN
  output logic [15:0]   ucount,
`endif
  output logic          halted
);
  cs_state_t     state_q;
  logic [DW-1:0] cw_q;
  logic          halted_q;
  logic          ready_q;
  logic [DW-1:0] rdata;
  logic          we;

  assign we = load_valid & ready_q & (state_q == LOAD);

  cs_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (micro_addr),
    .rdata_o (rdata)
  );

`ifdef CONTROL_STORE_UCOUNT_EN
  logic [15:0] ucount_q;
  assign ucount = ucount_q;
`endif

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      cw_q     <= '0;
      halted_q <= 1'b0;
      ready_q  <= 1'b0;
`ifdef CONTROL_STORE_UCOUNT_EN
      ucount_q <= '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          cw_q <= '0;
          if (load_done) begin
            state_q <= FETCH;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        FETCH: begin
          cw_q    <= rdata;
          state_q <= EXEC;
        end
        EXEC: begin
          cw_q <= '0;
`ifdef CONTROL_STORE_UCOUNT_EN
          if (ucount_q != 16'hFFFF) ucount_q <= ucount_q + 16'd1;
`endif
          if (cw_q[HALT_BIT]) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        HALT: begin
          cw_q <= '0;
          if (restart) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign control_signal = cw_q;
  assign halted         = halted_q;
  assign load_ready     = ready_q;
endmodule

// File: tb/tb_control_store.sv
// Scoreboard bench for control_store, closing the loop with a small
// control-address-register model (INC / DISPATCH / ZERO microword bits).
module tb_control_store;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  micro_addr;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_done = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] control_signal;
  logic        halted;
`ifdef CONTROL_STORE_UCOUNT_EN
  logic [15:0] ucount;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  logic [7:0] car = '0;
  logic       car_set = 1'b0;
  logic [7:0] car_val = '0;
  logic [7:0] opcode = 8'h02;

  control_store dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .micro_addr     (micro_addr),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_done      (load_done),
    .restart        (restart),
    .control_signal (control_signal),
`ifdef CONTROL_STORE_UCOUNT_EN
    .ucount         (ucount),
`endif
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Control address register: acts on the microword at the ending EXEC edge.
  always @(posedge clk) begin
    if (car_set)                 car <= car_val;
    else if (control_signal[2])  car <= 8'h00;
    else if (control_signal[1])  car <= opcode + 8'h07;
    else if (control_signal[0])  car <= car + 8'h01;
  end
  assign micro_addr = car;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(32'h0);
    exp_q.push_back(w);
  endtask

  // Called at the first FETCH negedge; one queue entry per cycle, then HALT.
  task automatic drain();
    logic [31:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("cs_seq", control_signal, w);
      chk("halted_low", {31'b0, halted}, 32'h0);
      @(negedge clk);
    end
    chk("halted_high", {31'b0, halted}, 32'h1);
    chk("cs_in_halt", control_signal, 32'h0);
  endtask

  task automatic set_car(input logic [7:0] v);
    car_set = 1'b1;
    car_val = v;
    @(negedge clk);
    car_set = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !load_ready; i++) @(negedge clk);
    if (!load_ready) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic done);
    wait_ready();
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    @(negedge clk);
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic chk_ucount(input logic [15:0] e);
`ifdef CONTROL_STORE_UCOUNT_EN
    chk("ucount", {16'h0, ucount}, {16'h0, e});
`else
    if (e == 16'hFFFF) $display("ucount %0d", e);
`endif
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_cs", control_signal, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_ready", {31'b0, load_ready}, 32'h0);
    chk_ucount(16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_in_load", {31'b0, load_ready}, 32'h1);
    chk("cs_in_load", control_signal, 32'h0);

    load_word(8'h00, 32'h0000_0001, 1'b0);
    load_word(8'h01, 32'h0000_0001, 1'b0);
    load_word(8'h02, 32'h8000_0004, 1'b0);
    load_word(8'h09, 32'h0000_0001, 1'b0);
    load_word(8'h0A, 32'h8000_0000, 1'b0);
    load_word(8'h0B, 32'h0000_0002, 1'b0);
    load_word(8'h05, 32'h1234_5678, 1'b0);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    chk("ready_drop", {31'b0, load_ready}, 32'h0);
    push_word(32'h0000_0001);
    push_word(32'h0000_0001);
    push_word(32'h8000_0004);
    drain();
    chk("car_zeroed", {24'h0, car}, 32'h0);
    chk_ucount(16'd3);

    // Writes and load_done outside LOAD are ignored.
    load_valid = 1'b1; load_addr = 8'h00; load_data = 32'hFFFF_FFFF; load_done = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; load_done = 1'b0;
    chk("halt_holds", {31'b0, halted}, 32'h1);

    do_restart();
    push_word(32'h0000_0001);
    push_word(32'h0000_0001);
    push_word(32'h8000_0004);
    drain();
    chk_ucount(16'd6);

    set_car(8'h0B);
    do_restart();
    push_word(32'h0000_0002);
    push_word(32'h0000_0001);
    push_word(32'h8000_0000);
    drain();
    chk("car_after_dispatch", {24'h0, car}, 32'h0A);
    chk_ucount(16'd9);

    set_car(8'h00);
    do_restart();
    @(negedge clk);
    chk("exec_before_rst", control_signal, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs", control_signal, 32'h0);
    chk("rst_mid_ready", {31'b0, load_ready}, 32'h0);
    chk("rst_mid_halted", {31'b0, halted}, 32'h0);
    chk_ucount(16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, load_ready}, 32'h1);

    set_car(8'h05);
    load_word(8'h05, 32'hDEAD_BEEF, 1'b1);
    chk("ready_drop2", {31'b0, load_ready}, 32'h0);
    push_word(32'hDEAD_BEEF);
    drain();
    chk_ucount(16'd1);

    do_restart();
    push_word(32'h0000_0001);
    push_word(32'h0000_0001);
    push_word(32'h8000_0004);
    drain();
    chk_ucount(16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/control_store.md
Name: control_store

Overview:
- Writable microprogram control memory (CM) with a microinstruction output register.
- Takes `micro_addr` from the control address register and drives the 32-bit `control_signal` microword back to it and to the datapath.
- Microcode is loaded over a valid/ready write port after reset. Execution then runs in a two-phase fetch/execute rhythm, so the address register advances exactly once per microinstruction.
- Sits directly downstream of the control address register and closes the micro-sequencing loop.

Parameters:
- AW, 8, microaddress width (store depth 2^AW words)
- DW, 32, microword width
- HALT_BIT, 31, microword bit that marks the final microinstruction of the program

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- micro_addr  in  AW  current microaddress from the control address register
- load_valid  in  1  microcode write request
- load_ready  out  1  store accepts writes (high only in LOAD)
- load_addr  in  AW  microcode write address
- load_data  in  DW  microcode write data
- load_done  in  1  end-of-load strobe
- restart  in  1  leave HALT and resume execution
- control_signal  out  DW  registered microword; zero except during EXEC phase
- halted  out  1  high in HALT state

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of `clk`.
  - State goes to LOAD. `control_signal`, `halted` and `load_ready` all reset to 0.
  - Store contents are NOT cleared.
  - Reset mid-run aborts the current microinstruction and forces `control_signal` to 0 at that edge.
- States: LOAD, FETCH, EXEC, HALT. A transition takes effect at the edge that ends the cycle.
- LOAD:
  - `load_ready` = 1.
  - `load_valid` & `load_ready` writes `load_data` to `mem[load_addr]` at the edge.
  - `load_done` moves the state to FETCH. If `load_valid` and `load_done` are both high in the same cycle, the write is performed, then the state moves to FETCH.
  - A rewrite of the same address keeps the last value.
  - `control_signal` = 0.
- FETCH:
  - `control_signal` reads 0, so the address register holds.
  - At the edge: `control_signal` <= `mem[micro_addr]` (asynchronous read), state -> EXEC.
- EXEC:
  - `control_signal` holds the fetched word for exactly one cycle, and the address register acts on it at the ending edge.
  - At the same edge: `control_signal` <= 0.
  - If `control_signal[HALT_BIT]` = 1, state -> HALT; otherwise state -> FETCH.
- Cadence: one microinstruction costs 2 cycles. Latency from address to microword is 1 edge.
- HALT:
  - `halted` = 1 and `control_signal` = 0.
  - `restart` -> FETCH at the next edge. The `micro_addr` present then is fetched.
- `load_valid` and `load_done` are ignored outside LOAD. `restart` is ignored outside HALT.
- `micro_addr` wraps naturally within AW bits. Every address is readable, and unwritten words read the value from the previous load (undefined after power-up).

Optional Feature:
- Macro: CONTROL_STORE_UCOUNT_EN
- When defined:
  - Extra output `ucount`, 16 bits, reset to 0.
  - Increments at each EXEC edge and saturates at 16'hFFFF.
  - Cleared on entering LOAD.
- When undefined: the port and counter are absent, with no other behavioural change.

Decomposition:
- Shared package `cpu_pkg` holds:
  - microword bit constants MW_INC=0, MW_DISPATCH=1, MW_ZERO=2, MW_HALT=31
  - AW/DW defaults
  - the state enum `cs_state_t` {LOAD, FETCH, EXEC, HALT}
- Sub-module `cs_ram`: AW x DW array, synchronous write, asynchronous read. The FSM and output register live in `control_store`.

Test Plan:
- Load 3 words {addr0=0x00000001, addr1=0x00000001, addr2=0x80000004}, then pulse `load_done` -> `load_ready` drops the next cycle; `control_signal` shows 0x1, 0, 0x1, 0, 0x80000004 on alternate cycles, then `halted`=1 with `control_signal`=0.
- `load_valid`=1, `load_addr`=0x05, `load_data`=0xDEADBEEF and `load_done`=1 in the same cycle; drive `micro_addr`=0x05 -> the next EXEC shows 0xDEADBEEF.
- Closed loop with the address register and opcode 0x02, `mem[0x09]`=0x1, `mem[0x0A]`=0x80000000 -> addresses step 0x09 to 0x0A, then halt after exactly 2 EXEC cycles.
- In HALT, pulse `restart` with `micro_addr`=0x00 -> FETCH next cycle, `mem[0]` visible one cycle later, `halted` low.
- Assert `rst_n`=0 during EXEC -> `control_signal`=0 at that edge, state LOAD, `load_ready`=1; previously loaded words are still read back after `load_done`.
- With CONTROL_STORE_UCOUNT_EN, run 4 microinstructions -> `ucount`=4; re-enter LOAD -> `ucount`=0.
